// File: rtl/spc_pkg.sv
// spc_pkg: shared state encoding and default framing constants for the SPC frame sequencer.
package spc_pkg;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_TAIL} spc_state_e;

    localparam int DEF_PRE_BITS = 16;
    localparam logic [DEF_PRE_BITS-1:0] DEF_PREAMBLE = 16'hF0A5;
    localparam int DEF_TAIL_BITS = 4;
    localparam int DEF_LEN_W = 10;

    // One counter serves all three fields, so it must hold the largest terminal count.
    function automatic int cnt_width(input int pre, input int tail, input int lw);
        int w;
        w = lw;
        if ($clog2(pre) > w) w = $clog2(pre);
        if ($clog2(tail) > w) w = $clog2(tail);
        return w;
    endfunction

endpackage

// File: rtl/spc_frame_ctrl_if.sv
// spc_frame_ctrl_if: upstream bit handshake, frame control and SPC drive signals of the frame sequencer.
interface spc_frame_ctrl_if import spc_pkg::*; #(
    parameter int LEN_W = DEF_LEN_W
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             abort;
    logic             din;
    logic             din_valid;
    logic             din_ready;
    logic             spc_en;
    logic             spc_din;
    logic             sym_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, frame_len, abort, din, din_valid,
        input  din_ready, spc_en, spc_din, sym_valid, busy, done
    );

    modport slave (
        input  start, frame_len, abort, din, din_valid,
        output din_ready, spc_en, spc_din, sym_valid, busy, done
    );
endinterface

// File: rtl/spc_frame_ctrl.sv
// spc_frame_ctrl: drives the SPC with preamble, handshaked payload and zero tail per frame,
// flagging the second bit of every pair as a symbol strobe.
module spc_frame_ctrl import spc_pkg::*; #(
    parameter int                  PRE_BITS  = DEF_PRE_BITS,
    parameter logic [PRE_BITS-1:0] PREAMBLE  = DEF_PREAMBLE,
    parameter int                  TAIL_BITS = DEF_TAIL_BITS,
    parameter int                  LEN_W     = DEF_LEN_W
) (
    input logic             clk,
    input logic             reset,
    spc_frame_ctrl_if.slave bus
);
    localparam int CW = cnt_width(PRE_BITS, TAIL_BITS, LEN_W);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_BITS - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'(TAIL_BITS - 1);

    spc_state_e       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, len_last;
    logic [LEN_W-1:0] len, len_nxt;
    logic             phase, phase_nxt, done_q, done_nxt, act;
    logic [PRE_BITS-1:0] pre_sh;

    assign len_last = CW'(len) - CW'(1);
    assign pre_sh   = PREAMBLE << cnt;
    assign act      = !bus.abort;

    // Outputs: abort kills the current bit combinationally, before the state returns to idle.
    always_comb begin
        bus.din_ready = act && state == S_PAYLOAD;
        bus.spc_en    = act && (state == S_PREAMBLE || state == S_TAIL ||
                                (state == S_PAYLOAD && bus.din_valid));
        bus.spc_din   = act && (state == S_PREAMBLE ? pre_sh[PRE_BITS-1] :
                                state == S_PAYLOAD && bus.din_valid && bus.din);
        bus.sym_valid = bus.spc_en && phase;
        bus.busy      = state != S_IDLE;
        bus.done      = done_q;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len;
        phase_nxt = bus.spc_en ? !phase : phase;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && act) begin
                    state_nxt = S_PREAMBLE;
                    len_nxt   = bus.frame_len & ~LEN_W'(1);
                    cnt_nxt   = '0;
                    phase_nxt = 1'b0;
                end
            end
            S_PREAMBLE: begin
                cnt_nxt = cnt == PRE_LAST ? '0 : cnt + CW'(1);
                if (cnt == PRE_LAST) state_nxt = len == '0 ? S_TAIL : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (bus.din_valid) begin
                    cnt_nxt = cnt == len_last ? '0 : cnt + CW'(1);
                    if (cnt == len_last) state_nxt = S_TAIL;
                end
            end
            S_TAIL: begin
                cnt_nxt = cnt == TAIL_LAST ? '0 : cnt + CW'(1);
                if (cnt == TAIL_LAST) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            phase_nxt = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            len    <= '0;
            phase  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            len    <= len_nxt;
            phase  <= phase_nxt;
            done_q <= done_nxt;
        end
    end

endmodule

// File: tb/tb_spc_frame_ctrl.sv
// tb_spc_frame_ctrl: directed test-plan scenarios plus random traffic, checked every cycle
// against a bit-position model of the frame.
module tb_spc_frame_ctrl;
    localparam int PRE = 16;
    localparam int TAIL = 4;
    localparam int LW = 10;
    localparam logic [PRE-1:0] PAT = 16'hF0A5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0, n_fail = 0;
    int cyc = 0, done_at = -1, pi = 0, rdy_cnt = 0;
    logic [63:0] pat = '0;
    logic [31:0] seen = '0;
    bit m_act = 0, m_done = 0;
    int m_pos = 0, m_len = 0;
    string tag = "reset";

    spc_frame_ctrl_if #(.LEN_W(LW)) bus();

    spc_frame_ctrl #(.PRE_BITS(PRE), .PREAMBLE(PAT), .TAIL_BITS(TAIL), .LEN_W(LW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] observed();
        return {bus.din_ready, bus.spc_en, bus.spc_din, bus.sym_valid, bus.busy, bus.done};
    endfunction

    // Expected {din_ready, spc_en, spc_din, sym_valid, busy, done} from the bit position in the frame.
    function automatic logic [5:0] expected();
        logic en, b, rdy;
        if (!reset) return 6'b0;
        if (!m_act) return {5'b0, m_done};
        if (bus.abort) return 6'b000010;
        if (m_pos < PRE) begin
            en = 1'b1; rdy = 1'b0; b = PAT[PRE-1-m_pos];
        end else if (m_pos < PRE + m_len) begin
            rdy = 1'b1; en = bus.din_valid; b = en & bus.din;
        end else begin
            en = 1'b1; rdy = 1'b0; b = 1'b0;
        end
        return {rdy, en, b, en && (m_pos % 2 == 1), 1'b1, 1'b0};
    endfunction

    task automatic check(input string name, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", name, obs, exp);
        end
    endtask

    task automatic tick();
        logic [5:0] e, o;
        @(negedge clk);
        e = expected();
        o = observed();
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d rdy/en/din/sv/busy/done observed %b expected %b", tag, cyc, o, e);
        end
        if (bus.done) done_at = cyc;
        if (bus.spc_en) seen = {seen[30:0], bus.spc_din};
        if (bus.din_ready) rdy_cnt++;
        @(posedge clk);
        if (!reset) begin
            m_act = 0; m_pos = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_act) begin
                if (bus.abort) m_act = 0;
                else if (e[4]) begin
                    if (e[5]) pi++;
                    m_pos++;
                    if (m_pos == PRE + m_len + TAIL) begin
                        m_act = 0; m_done = 1;
                    end
                end
            end else if (bus.start && !bus.abort) begin
                m_act = 1; m_pos = 0; m_len = int'(bus.frame_len) & ~1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            bus.din = pat[pi % 64];
            tick();
        end
    endtask

    task automatic start_frame(input int len);
        bus.frame_len = LW'(len);
        bus.start = 1'b1;
        cyc = 0; done_at = -1; pi = 0; seen = '0; rdy_cnt = 0;
        run(1);
        bus.start = 1'b0;
        bus.frame_len = LW'($urandom);
    endtask

    initial begin
        bus.start = 0; bus.frame_len = '0; bus.abort = 0; bus.din = 0; bus.din_valid = 0;
        #1;
        check("reset_outputs", int'(observed()), 0);
        tick(); tick();
        reset = 1'b1;

        tag = "basic";
        bus.din_valid = 1'b1;
        pat = 64'b1101;
        start_frame(4);
        run(25);
        check("basic_done_cycle", done_at, 25);
        check("basic_bitstream", int'(seen[23:0]), 32'hF0A5B0);

        tag = "stall";
        pat = 64'($urandom);
        start_frame(6);
        run(17);
        bus.din_valid = 1'b0;
        run(2);
        bus.din_valid = 1'b1;
        run(10);
        check("stall_done_cycle", done_at, 29);

        tag = "len0";
        start_frame(0);
        run(21);
        check("len0_done_cycle", done_at, 21);
        check("len0_no_ready", rdy_cnt, 0);
        tag = "len1";
        start_frame(1);
        run(21);
        check("len1_done_cycle", done_at, 21);
        check("len1_no_ready", rdy_cnt, 0);

        tag = "abort";
        start_frame(10);
        run(9);
        bus.abort = 1'b1;
        run(1);
        bus.abort = 1'b0;
        run(1);
        check("abort_no_done", done_at, -1);
        check("abort_busy_c11", int'(bus.busy), 0);
        bus.frame_len = LW'(4);
        bus.start = 1'b1;
        run(1);
        bus.start = 1'b0;
        run(25);
        check("abort_restart_done", done_at, 37);

        tag = "reset_mid";
        start_frame(8);
        run(17);
        reset = 1'b0;
        #1;
        check("reset_mid_outputs", int'(observed()), 0);
        tick(); tick();
        check("reset_mid_no_done", done_at, -1);
        reset = 1'b1;
        start_frame(4);
        run(25);
        check("reset_mid_rerun_done", done_at, 25);

        tag = "start_pulses";
        start_frame(4);
        run(4);
        bus.start = 1'b1;
        run(1);
        bus.start = 1'b0;
        run(19);
        bus.start = 1'b1;
        bus.frame_len = LW'(2);
        run(1);
        bus.start = 1'b0;
        check("pulse_first_done", done_at, 25);
        run(23);
        check("pulse_second_done", done_at, 48);

        tag = "random";
        repeat (3000) begin
            bus.start = ($urandom % 8) == 0;
            bus.abort = ($urandom % 64) == 0;
            bus.frame_len = LW'($urandom % 32);
            bus.din_valid = ($urandom % 4) != 0;
            bus.din = 1'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
